// File: rtl/ifm_addr_pkg.sv
// rtl/ifm_addr_pkg.sv - shared state encoding and sizing helpers for the IFM window address generator
package ifm_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int DEF_SYSTOLIC_SIZE = 16;
  localparam int KMAX              = 3;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ifm_win_counter.sv
// rtl/ifm_win_counter.sv - cascaded kx/ky/c/oy/tile loop counters with per-level wrap flags
module ifm_win_counter
  import ifm_addr_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int CH_W          = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            adv,
  input  logic [1:0]      k_m1,
  input  logic [CH_W-1:0] c_m1,
  input  logic [8:0]      oy_m1,
  input  logic [8:0]      ofm_size,
  output logic            kx_wrap,
  output logic            ky_wrap,
  output logic            c_wrap,
  output logic            oy_wrap,
  output logic            t_wrap
);

  logic [1:0]      kx_q;
  logic [1:0]      ky_q;
  logic [CH_W-1:0] c_q;
  logic [8:0]      oy_q;
  logic [15:0]     tcol_q;
  logic [15:0]     tcol_nx;

  // The tile counter holds the first output column of the tile, so no divide is needed.
  assign tcol_nx = tcol_q + 16'(SYSTOLIC_SIZE);
  assign kx_wrap = (kx_q == k_m1);
  assign ky_wrap = (ky_q == k_m1);
  assign c_wrap  = (c_q == c_m1);
  assign oy_wrap = (oy_q == oy_m1);
  assign t_wrap  = (tcol_nx >= {7'd0, ofm_size});

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      kx_q   <= '0;
      ky_q   <= '0;
      c_q    <= '0;
      oy_q   <= '0;
      tcol_q <= '0;
    end else if (adv) begin
      if (!kx_wrap) begin
        kx_q <= kx_q + 2'd1;
      end else begin
        kx_q <= '0;
        if (!ky_wrap) begin
          ky_q <= ky_q + 2'd1;
        end else begin
          ky_q <= '0;
          if (!c_wrap) begin
            c_q <= c_q + CH_W'(1);
          end else begin
            c_q <= '0;
            if (!oy_wrap) begin
              oy_q <= oy_q + 9'd1;
            end else begin
              oy_q   <= '0;
              tcol_q <= t_wrap ? '0 : tcol_nx;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/ifm_window_addr_gen.sv
// rtl/ifm_window_addr_gen.sv - streams IFM read addresses for every KxKxC window; IFM_ADDR_GEN_PAD_EN adds padded taps
module ifm_window_addr_gen
  import ifm_addr_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int IFM_RAM_SIZE  = 524172,
  parameter int KMAX          = ifm_addr_pkg::KMAX,
  parameter int CH_W          = 11,
  parameter int ADDR_W        = addr_w(IFM_RAM_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              win_last,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [8:0]        ifm_size,
  input  logic [17:0]       channel_size,
  input  logic [CH_W-1:0]   ifm_channel,
  input  logic [8:0]        ofm_size,
  input  logic [1:0]        kernel_size,
  input  logic              stride2
`ifdef IFM_ADDR_GEN_PAD_EN
  ,
  input  logic              pad_en,
  output logic              addr_pad
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [8:0]        ifm_q, ofm_q;
  logic [17:0]       cs_q;
  logic [CH_W-1:0]   ch_q;
  logic [1:0]        k_q, k_eff;
  logic              s2_q;
  logic [ADDR_W-1:0] tile_ptr_q, row_ptr_q, ch_ptr_q, line_ptr_q, addr_q;
  logic [ADDR_W-1:0] ifm_step, ch_step, row_step, tile_step, org;
  logic [ADDR_W-1:0] line_nx, ch_nx, row_nx, tile_nx;
  logic              kx_wrap, ky_wrap, c_wrap, oy_wrap, t_wrap;
  logic              adv, last_win, empty_layer;

  assign k_eff       = (kernel_size > 2'(KMAX)) ? 2'(KMAX) : kernel_size;
  assign ifm_step    = ADDR_W'(ifm_q);
  assign ch_step     = ADDR_W'(cs_q);
  assign row_step    = s2_q ? ADDR_W'({ifm_q, 1'b0}) : ifm_step;
  assign tile_step   = ADDR_W'(s2_q ? 2 * SYSTOLIC_SIZE : SYSTOLIC_SIZE);
  assign line_nx     = line_ptr_q + ifm_step;
  assign ch_nx       = ch_ptr_q + ch_step;
  assign row_nx      = row_ptr_q + row_step;
  assign tile_nx     = tile_ptr_q + tile_step;
  assign adv         = addr_valid && addr_ready;
  assign win_last    = addr_valid && kx_wrap && ky_wrap && c_wrap;
  assign last_win    = win_last && oy_wrap && t_wrap;
  assign empty_layer = (ofm_q == 9'd0) || (ch_q == '0) || (k_q == 2'd0);

  ifm_win_counter #(
    .SYSTOLIC_SIZE(SYSTOLIC_SIZE),
    .CH_W         (CH_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == ST_LOAD),
    .adv     (adv),
    .k_m1    (k_q - 2'd1),
    .c_m1    (ch_q - CH_W'(1)),
    .oy_m1   (ofm_q - 9'd1),
    .ofm_size(ofm_q),
    .kx_wrap (kx_wrap),
    .ky_wrap (ky_wrap),
    .c_wrap  (c_wrap),
    .oy_wrap (oy_wrap),
    .t_wrap  (t_wrap)
  );

`ifdef IFM_ADDR_GEN_PAD_EN
  // Signed tap coordinates track the padded window so out-of-image taps can be flagged.
  logic                pad_en_q, tap_pad;
  logic signed [12:0]  prow_win_q, prow_q, pcol_tile_q, pcol_q;
  logic signed [12:0]  pad_sh, ifm_s, prow_step, ptile_step;

  assign pad_sh     = pad_en_q ? 13'sd1 : 13'sd0;
  assign ifm_s      = $signed({4'd0, ifm_q});
  assign prow_step  = s2_q ? 13'sd2 : 13'sd1;
  assign ptile_step = $signed(13'(s2_q ? 2 * SYSTOLIC_SIZE : SYSTOLIC_SIZE));
  assign tap_pad    = pad_en_q && (prow_q < 13'sd0 || prow_q >= ifm_s ||
                                   pcol_q < 13'sd0 || pcol_q >= ifm_s);
  assign org        = base_q - (pad_en_q ? ifm_step + ADDR_W'(1) : '0);
  assign ifm_addr   = tap_pad ? base_q : addr_q;
  assign addr_pad   = addr_valid && tap_pad;
`else
  assign org      = base_q;
  assign ifm_addr = addr_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    done       = 1'b0;
    addr_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = empty_layer ? ST_DONE : ST_RUN;
      ST_RUN: begin
        addr_valid = 1'b1;
        if (adv && last_win) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Each loop level owns a pointer; a wrap reloads every inner pointer from the next one out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q     <= '0;
      ifm_q      <= '0;
      ofm_q      <= '0;
      cs_q       <= '0;
      ch_q       <= '0;
      k_q        <= '0;
      s2_q       <= 1'b0;
      tile_ptr_q <= '0;
      row_ptr_q  <= '0;
      ch_ptr_q   <= '0;
      line_ptr_q <= '0;
      addr_q     <= '0;
`ifdef IFM_ADDR_GEN_PAD_EN
      pad_en_q    <= 1'b0;
      prow_win_q  <= '0;
      prow_q      <= '0;
      pcol_tile_q <= '0;
      pcol_q      <= '0;
`endif
    end else begin
      if (state_q == ST_IDLE && start) begin
        base_q <= base_addr;
        ifm_q  <= ifm_size;
        ofm_q  <= ofm_size;
        cs_q   <= channel_size;
        ch_q   <= ifm_channel;
        k_q    <= k_eff;
        s2_q   <= stride2;
`ifdef IFM_ADDR_GEN_PAD_EN
        pad_en_q <= pad_en;
`endif
      end
      if (state_q == ST_LOAD) begin
        tile_ptr_q <= org;
        row_ptr_q  <= org;
        ch_ptr_q   <= org;
        line_ptr_q <= org;
        addr_q     <= org;
`ifdef IFM_ADDR_GEN_PAD_EN
        prow_win_q  <= -pad_sh;
        prow_q      <= -pad_sh;
        pcol_tile_q <= -pad_sh;
        pcol_q      <= -pad_sh;
`endif
      end else if (adv) begin
        if (!kx_wrap) begin
          addr_q <= addr_q + ADDR_W'(1);
        end else if (!ky_wrap) begin
          line_ptr_q <= line_nx;
          addr_q     <= line_nx;
        end else if (!c_wrap) begin
          ch_ptr_q   <= ch_nx;
          line_ptr_q <= ch_nx;
          addr_q     <= ch_nx;
        end else if (!oy_wrap) begin
          row_ptr_q  <= row_nx;
          ch_ptr_q   <= row_nx;
          line_ptr_q <= row_nx;
          addr_q     <= row_nx;
        end else begin
          tile_ptr_q <= tile_nx;
          row_ptr_q  <= tile_nx;
          ch_ptr_q   <= tile_nx;
          line_ptr_q <= tile_nx;
          addr_q     <= tile_nx;
        end
`ifdef IFM_ADDR_GEN_PAD_EN
        if (!kx_wrap) begin
          pcol_q <= pcol_q + 13'sd1;
        end else begin
          pcol_q <= pcol_tile_q;
          if (!ky_wrap) begin
            prow_q <= prow_q + 13'sd1;
          end else if (!c_wrap) begin
            prow_q <= prow_win_q;
          end else if (!oy_wrap) begin
            prow_win_q <= prow_win_q + prow_step;
            prow_q     <= prow_win_q + prow_step;
          end else begin
            prow_win_q  <= -pad_sh;
            prow_q      <= -pad_sh;
            pcol_tile_q <= pcol_tile_q + ptile_step;
            pcol_q      <= pcol_tile_q + ptile_step;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ifm_window_addr_gen.sv
// tb/tb_ifm_window_addr_gen.sv - scoreboard bench for ifm_window_addr_gen
`timescale 1ns/1ps
module tb_ifm_window_addr_gen;

  localparam int SS   = 16;
  localparam int AW   = $clog2(524172);
  localparam int CH_W = 11;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, addr_valid, addr_ready, win_last, stride2;
  logic [AW-1:0] ifm_addr, base_addr;
  logic [8:0]    ifm_size, ofm_size;
  logic [17:0]   channel_size;
  logic [CH_W-1:0] ifm_channel;
  logic [1:0]    kernel_size;
`ifdef IFM_ADDR_GEN_PAD_EN
  logic          pad_en, addr_pad;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
    logic          pad;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          got_e;
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            last_hs_cyc = 0;
  int            ready_pct = 100;
  logic          stall_prev = 1'b0;
  logic [AW-1:0] stall_addr;
  logic          stall_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifm_window_addr_gen #(
    .SYSTOLIC_SIZE(SS),
    .IFM_RAM_SIZE (524172),
    .KMAX         (3),
    .CH_W         (CH_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .ifm_addr    (ifm_addr),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .win_last    (win_last),
    .base_addr   (base_addr),
    .ifm_size    (ifm_size),
    .channel_size(channel_size),
    .ifm_channel (ifm_channel),
    .ofm_size    (ofm_size),
    .kernel_size (kernel_size),
    .stride2     (stride2)
`ifdef IFM_ADDR_GEN_PAD_EN
    ,
    .pad_en      (pad_en),
    .addr_pad    (addr_pad)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: direct formula with multiplies, in loop order kx, ky, c, oy, t.
  task automatic push_model(input int base, input int ifm, input int cs, input int c_n,
                            input int ofm, input int k, input int s2, input int pad_on);
    int s;
    s = s2 ? 2 : 1;
    for (int t = 0; t * SS < ofm; t++)
      for (int oy = 0; oy < ofm; oy++)
        for (int c = 0; c < c_n; c++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              exp_t   m;
              longint row, col, a;
              row   = oy * s + ky - pad_on;
              col   = t * SS * s + kx - pad_on;
              m.pad = (pad_on != 0) && (row < 0 || row >= ifm || col < 0 || col >= ifm);
              a     = m.pad ? longint'(base)
                            : longint'(base) + longint'(c) * cs + row * ifm + col;
              m.addr = a[AW-1:0];
              m.last = (kx == k - 1) && (ky == k - 1) && (c == c_n - 1);
              exp_q.push_back(m);
            end
  endtask

  task automatic drive_cfg(input int base, input int ifm, input int cs, input int c_n,
                           input int ofm, input int k, input int s2, input int pad_on);
    base_addr    = AW'(base);
    ifm_size     = 9'(ifm);
    channel_size = 18'(cs);
    ifm_channel  = CH_W'(c_n);
    ofm_size     = 9'(ofm);
    kernel_size  = 2'(k);
    stride2      = s2[0];
`ifdef IFM_ADDR_GEN_PAD_EN
    pad_en       = pad_on[0];
`endif
  endtask

  task automatic scramble_cfg();
    base_addr    = AW'($urandom);
    ifm_size     = 9'($urandom);
    channel_size = 18'($urandom);
    ifm_channel  = CH_W'($urandom);
    ofm_size     = 9'($urandom);
    kernel_size  = 2'($urandom);
    stride2      = 1'($urandom);
  endtask

  task automatic run_layer(input string name, input int base, input int ifm, input int cs,
                           input int c_n, input int ofm, input int k, input int s2,
                           input int pad_on, input int rdy_pct);
    int d0, n, start_cyc, guard;
    exp_q.delete();
    push_model(base, ifm, cs, c_n, ofm, k, s2, pad_on);
    n = exp_q.size();
    ready_pct = rdy_pct;
    @(posedge clk); #1;
    drive_cfg(base, ifm, cs, c_n, ofm, k, s2, pad_on);
    start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check({name, "_busy_load"}, busy, 1);
    check({name, "_valid_load"}, addr_valid, 0);
    scramble_cfg();
    guard = 0;
    while (done_cnt == d0 && guard < n * 8 + 64) begin
      @(posedge clk); #1;
      guard++;
      start = (guard == 5 && n > 20);
      if (guard == 1) check({name, "_valid_rise"}, addr_valid, n > 0);
    end
    start = 1'b0;
    check({name, "_done_seen"}, done_cnt - d0, 1);
    check({name, "_left_in_queue"}, exp_q.size(), 0);
    if (rdy_pct >= 100) check({name, "_done_cycle"}, done_cyc - start_cyc, n + 1);
    if (n > 0) check({name, "_done_after_last"}, done_cyc - last_hs_cyc, 1);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_single_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    addr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      addr_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid", addr_valid, 1);
        check("stall_addr", ifm_addr, stall_addr);
        check("stall_last", win_last, stall_last);
      end
      if (addr_valid && addr_ready) begin
        last_hs_cyc = cyc;
        check("exp_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          got_e = exp_q.pop_front();
          check("addr", ifm_addr, got_e.addr);
          check("win_last", win_last, got_e.last);
`ifdef IFM_ADDR_GEN_PAD_EN
          check("addr_pad", addr_pad, got_e.pad);
`endif
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = addr_valid && !addr_ready;
      stall_addr = ifm_addr;
      stall_last = win_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_valid", addr_valid, 0);
    check("reset_done", done, 0);
    check("reset_addr", ifm_addr, 0);
    check("reset_win_last", win_last, 0);
`ifdef IFM_ADDR_GEN_PAD_EN
    check("reset_addr_pad", addr_pad, 0);
`endif
    rst_n = 1'b1;

    run_layer("k3s1",      100, 8, 64, 2, 6, 3, 0, 0, 100);
    run_layer("k1s2",      40, 8, 64, 1, 4, 1, 1, 0, 100);
    run_layer("k3s1_rdy",  100, 8, 64, 2, 6, 3, 0, 0, 50);
    run_layer("tiles",     200, 24, 600, 1, 20, 3, 0, 0, 100);
    run_layer("k2s2_tile", 7, 48, 3000, 3, 18, 2, 1, 0, 50);
    run_layer("ofm0",      100, 8, 64, 2, 0, 3, 0, 0, 100);
    run_layer("ch0",       100, 8, 64, 0, 6, 3, 0, 0, 100);
    run_layer("k0",        100, 8, 64, 2, 6, 0, 0, 0, 100);
    run_layer("addr_wrap", (1 << AW) - 20, 8, 64, 2, 3, 3, 0, 0, 100);

    // Reset in the middle of a run, with a coincident start that must be ignored.
    exp_q.delete();
    push_model(100, 8, 64, 2, 6, 3, 0, 0);
    ready_pct = 100;
    @(posedge clk); #1;
    drive_cfg(100, 8, 64, 2, 6, 3, 0, 0);
    start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", addr_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_addr", ifm_addr, 0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_start_ignored", busy, 0);
    run_layer("replay", 100, 8, 64, 2, 6, 3, 0, 0, 100);

`ifdef IFM_ADDR_GEN_PAD_EN
    run_layer("pad_k3",     100, 8, 64, 2, 6, 3, 0, 1, 100);
    run_layer("pad_k3_rdy", 500, 10, 128, 1, 5, 3, 1, 1, 50);
    run_layer("pad_off",    100, 8, 64, 2, 6, 3, 0, 0, 100);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
